// File: rtl/calc_exec_if.sv
// calc_exec_if: request/response bundle between the calculator controller
// (master) and the execution stage (slave).
interface calc_exec_if #(
  parameter int W = 8
);
  logic           start;
  logic [2:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;

  modport master (
    output start, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/calc_exec.sv
// calc_exec: execution stage of the calculator datapath.
// ADD/SUB/XOR finish in one clock. MUL is an iterative shift-add taking W+1
// cycles from start to done.
// Build option CALC_FAST_MUL_EN: when defined, MUL is a single-cycle
// combinational product, and the S_MUL state and its counter are not built.
module calc_exec #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst,
  calc_exec_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_IDLE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_XOR  = 3'd4
  } op_e;

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;
  logic [W:0]     diff;
  logic           simple_valid;
  logic [2*W-1:0] simple_res;
  logic           idle;
  logic           finish_mul;
  logic [2*W-1:0] mul_res;

  assign a_ext = {{W{1'b0}}, bus.a};
  assign b_ext = {{W{1'b0}}, bus.b};
  assign diff  = {1'b0, bus.a} - {1'b0, bus.b};

  // Decode ops that complete at the sampling edge and form their result.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    simple_valid = 1'b0;
    simple_res   = '0;
    case (bus.op)
      OP_ADD: begin
        simple_valid = 1'b1;
        simple_res   = a_ext + b_ext;
      end
      OP_SUB: begin
        simple_valid = 1'b1;
        simple_res   = {{(W-1){diff[W]}}, diff};
      end
      OP_XOR: begin
        simple_valid = 1'b1;
        simple_res   = a_ext ^ b_ext;
      end
`ifdef CALC_FAST_MUL_EN
      OP_MUL: begin
        simple_valid = 1'b1;
        simple_res   = a_ext * b_ext;
      end
`endif
      default: ;
    endcase
  end

`ifdef CALC_FAST_MUL_EN

  assign idle       = 1'b1;
  assign finish_mul = 1'b0;
  assign mul_res    = '0;
  assign bus.busy   = 1'b0;

`else

  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e         state;
  state_e         state_next;
  logic           load_mul;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_next;
  logic [CW-1:0]  cnt;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign idle     = (state == S_IDLE);
  assign bus.busy = (state == S_MUL);
  assign mul_res  = acc_next;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: accept a MUL in idle, leave S_MUL on the last iteration.
  always_comb begin
    state_next = state;
    load_mul   = 1'b0;
    finish_mul = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && bus.op == OP_MUL) begin
          load_mul   = 1'b1;
          state_next = S_MUL;
        end
      end
      S_MUL: begin
        if (cnt == CW'(1)) begin
          finish_mul = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Shift-add multiplier: one partial product per cycle while in S_MUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load_mul) begin
      mcand  <= a_ext;
      mplier <= bus.b;
      acc    <= '0;
      cnt    <= CW'(W);
    end else if (state == S_MUL) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_next;
      cnt    <= cnt - CW'(1);
    end
  end

`endif

  // Result register and done pulse: update only at a completion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result <= '0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (idle && bus.start && simple_valid) begin
        bus.result <= simple_res;
        bus.done   <= 1'b1;
      end else if (finish_mul) begin
        bus.result <= mul_res;
        bus.done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_exec.sv
// tb_calc_exec: directed-vector bench for calc_exec with hand-computed
// expectations. Outputs are sampled 1 time unit after each rising edge.
module tb_calc_exec;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   n_done;
  int   lat;
  logic [2*W-1:0] last_res;

  calc_exec_if #(.W(W)) bus ();

  calc_exec #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge, then drop start.
  task automatic apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    check("reset_busy",   32'(bus.busy),   32'd0);
    check("reset_done",   32'(bus.done),   32'd0);
    check("reset_result", 32'(bus.result), 32'h0000);
    rst = 1'b0;
    tick();

    // ADD with carry into bit W.
    apply(3'd1, 8'd200, 8'd100);
    check("add_done",   32'(bus.done),   32'd1);
    check("add_result", 32'(bus.result), 32'h012C);
    check("add_busy",   32'(bus.busy),   32'd0);
    tick();
    check("add_done_pulse", 32'(bus.done), 32'd0);

    // SUB negative and positive, then XOR, back to back.
    apply(3'd2, 8'd5, 8'd7);
    check("sub_neg_result", 32'(bus.result), 32'hFFFE);
    check("sub_neg_done",   32'(bus.done),   32'd1);
    apply(3'd2, 8'd7, 8'd5);
    check("sub_pos_result", 32'(bus.result), 32'h0002);
    apply(3'd4, 8'hF0, 8'h3C);
    check("xor_result", 32'(bus.result), 32'h00CC);
    check("xor_done",   32'(bus.done),   32'd1);

    // IDLE and reserved opcodes are ignored.
    apply(3'd0, 8'd9, 8'd9);
    check("op0_done",   32'(bus.done),   32'd0);
    check("op0_result", 32'(bus.result), 32'h00CC);
    apply(3'd6, 8'd9, 8'd9);
    check("op6_done",   32'(bus.done),   32'd0);
    check("op6_result", 32'(bus.result), 32'h00CC);

    // MUL 255*255, start sampled at edge k; now in cycle k+1.
    apply(3'd3, 8'd255, 8'd255);
`ifndef CALC_FAST_MUL_EN
    for (int i = 1; i <= W; i++) begin
      check($sformatf("mul_busy_c%0d", i), 32'(bus.busy), 32'd1);
      check($sformatf("mul_done_c%0d", i), 32'(bus.done), 32'd0);
      tick();
    end
`endif
    check("mul_done",   32'(bus.done),   32'd1);
    check("mul_result", 32'(bus.result), 32'hFE01);
    check("mul_busy_end", 32'(bus.busy), 32'd0);
    tick();
    check("mul_done_pulse", 32'(bus.done), 32'd0);

    // ADD issued during a MUL is dropped; only the MUL reports.
    apply(3'd4, 8'h00, 8'h01);
    check("xor_pre_result", 32'(bus.result), 32'h0001);
    apply(3'd3, 8'd255, 8'd255);
    n_done   = 0;
    last_res = '0;
    for (int c = 1; c <= 12; c++) begin
      if (bus.done) begin
        n_done++;
        last_res = bus.result;
      end
      bus.start = (c == 3);
      bus.op    = 3'd1;
      bus.a     = 8'd1;
      bus.b     = 8'd1;
      tick();
    end
    bus.start = 1'b0;
`ifndef CALC_FAST_MUL_EN
    check("busy_ign_ndone",  32'(n_done),     32'd1);
    check("busy_ign_result", 32'(last_res),   32'hFE01);
    check("busy_ign_final",  32'(bus.result), 32'hFE01);
`else
    check("busy_ign_ndone",  32'(n_done),     32'd2);
    check("busy_ign_final",  32'(bus.result), 32'h0002);
`endif

    // Reset at edge k+4 of a MUL aborts it without a done.
    apply(3'd3, 8'd3, 8'd4);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_mul_busy",   32'(bus.busy),   32'd0);
    check("rst_mul_done",   32'(bus.done),   32'd0);
    check("rst_mul_result", 32'(bus.result), 32'h0000);
    rst    = 1'b0;
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.done) n_done++;
      tick();
    end
    check("rst_no_done", 32'(n_done), 32'd0);

    // Fresh MUL after the abort, bounded wait for done.
    apply(3'd3, 8'd3, 8'd4);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) begin
        lat = c;
        break;
      end
      tick();
    end
`ifndef CALC_FAST_MUL_EN
    check("mul34_latency", 32'(lat), 32'(W));
`else
    check("mul34_latency", 32'(lat), 32'd0);
`endif
    check("mul34_result", 32'(bus.result), 32'h000C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calc_exec.md
# calc_exec

Execution stage of the calculator datapath: consumes the 3-bit operation code produced by the key-select decoder and performs ADD, SUB, MUL or XOR on two latched operands. Single-cycle operations complete in one clock; MUL is an iterative shift-add. A start/busy/done handshake connects the block to the calculator controller. The registered result feeds the display path.

## Interface
- W, 8, operand width; result width is 2*W; W ≥ 2.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request pulse; sampled only while busy=0.
- op  in  3  operation code: 3'd0 IDLE, 3'd1 ADD, 3'd2 SUB, 3'd3 MUL, 3'd4 XOR; 5–7 reserved.
- a  in  W  operand A, unsigned.
- b  in  W  operand B, unsigned.
- busy  out  1  high while a MUL iteration is in progress.
- done  out  1  one-cycle pulse, high in the cycle after result updates.
- result  out  2*W  last completed result; holds until the next completion.

## Operation
- States: S_IDLE, S_MUL.
- In S_IDLE, a start with op in {ADD, SUB, XOR} completes at the same edge:
  - result and done=1 are registered; the state stays S_IDLE.
- In S_IDLE, a start with op=MUL latches a, b and clears the accumulator.
  - Loads counter with W and enters S_MUL; busy=1.
- A start with op=IDLE or a reserved code is ignored: no done, result unchanged.
- A start while busy=1 is ignored and not queued; a, b and op are don't-care while busy.
- Arithmetic, all unsigned on the inputs:
  - ADD: result = zero-extend(a + b) to 2W; the carry lands in bit W.
  - SUB: the (W+1)-bit difference {0,a} − {0,b}, sign-extended from bit W to 2W. Example: 5−7 gives all-ones minus 1.
  - XOR: result = zero-extend(a ^ b).
  - MUL: full 2W-bit unsigned product.
- S_MUL performs one iteration per cycle:
  - If the multiplier LSB is 1, add the shifted multiplicand to the accumulator.
  - Shift the multiplicand left and the multiplier right; decrement the counter.
  - At the edge where the counter reaches 0: result ← accumulator, done=1, busy=0, return to S_IDLE.
- done is high for exactly one cycle per accepted request.
- A new start may be sampled in the same cycle that done is high.
- rst has priority over everything:
  - Sets state S_IDLE, busy=0, done=0, result=0, and clears the counter and accumulator.
  - An in-flight MUL aborts with no done.

## Timing
- Reset values: busy=0, done=0, result=0.
- ADD/SUB/XOR: start sampled at edge k; result valid and done=1 in cycle k+1 (latency 1).
- MUL (iterative): start sampled at edge k.
  - busy=1 during cycles k+1 … k+W.
  - result valid and done=1 in cycle k+W+1, with busy=0 in that cycle (latency W+1).
- Throughput: one simple operation per cycle; one MUL per W+1 cycles.
- result changes only at a completion edge or on reset.

## Configuration
- CALC_FAST_MUL_EN defined: MUL is computed combinationally as a*b and registered like the other ops.
  - Latency 1, busy never asserts, and S_MUL with its counter is not built.
- CALC_FAST_MUL_EN undefined: MUL uses the W-cycle shift-add sequence described above.
- Arithmetic results are identical in both builds.

## Test plan
- W=8, ADD: start with a=200, b=100 → one cycle later done=1 and result=16'h012C; busy stays 0.
- SUB: a=5, b=7 → result=16'hFFFE after 1 cycle.
- SUB: a=7, b=5 → result=16'h0002.
- XOR: a=8'hF0, b=8'h3C → result=16'h00CC.
- MUL (macro undefined): a=255, b=255, start at edge k.
  - busy=1 in cycles k+1…k+8.
  - done=1 and result=16'hFE01 in cycle k+9.
- MUL (macro defined): the same stimulus gives done at k+1 and busy never asserts.
- Pulse start with op=ADD, a=1, b=1 at k+3 during a MUL → ignored.
  - Only one done appears, with result 16'hFE01.
- op=3'd0 or 3'd6 with start → no done and result unchanged.
- Assert rst at k+4 of a MUL with a=3, b=4 → next cycle busy=0, done=0, result=0.
  - No done follows.
  - A subsequent MUL 3×4 completes with result=16'h000C.
